// File: rtl/object_centroid.sv
// object_centroid
//   Accumulates the coordinates of every object pixel in a video frame and, at
//   frame end, divides the coordinate sums by the pixel count to get the
//   object's mean position. The result is held until the next publish.
//
// Ports
//   clk, aresetn          clock, asynchronous active-low reset
//   enable                accumulation enable (pixels ignored when low)
//   pix_valid             x_pos/y_pos/pix_active valid this cycle
//   pix_active            pixel is part of the object mask
//   x_pos, y_pos          current pixel column / row
//   frame_end             one-cycle pulse after the last pixel of a frame
//   x_obj, y_obj          registered centroid column / row
//   obj_valid             last processed frame produced a valid centroid
//   done                  one-cycle pulse when x_obj/y_obj/obj_valid update
//   busy                  divider active
//   overrun               one-cycle pulse: frame_end arrived while busy
module object_centroid #(
    parameter int DISP_WIDTH = 11,
    parameter int CNT_WIDTH  = 19,
    parameter int SUM_WIDTH  = 30,
    parameter int MIN_PIXELS = 16
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic                  pix_valid,
    input  logic                  pix_active,
    input  logic [DISP_WIDTH-1:0] x_pos,
    input  logic [DISP_WIDTH-1:0] y_pos,
    input  logic                  frame_end,
    output logic [DISP_WIDTH-1:0] x_obj,
    output logic [DISP_WIDTH-1:0] y_obj,
    output logic                  obj_valid,
    output logic                  done,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [1:0] ST_ACCUM   = 2'd0;
    localparam logic [1:0] ST_DIV     = 2'd1;
    localparam logic [1:0] ST_PUBLISH = 2'd2;
    localparam int         IW         = $clog2(SUM_WIDTH + 1);

    logic [1:0]           state;
    logic [SUM_WIDTH-1:0] sum_x, sum_y;
    logic [CNT_WIDTH-1:0] count;

    // Frame totals including a pixel that lands in the frame_end cycle.
    logic                 qual;
    logic [SUM_WIDTH-1:0] tot_x, tot_y;
    logic [CNT_WIDTH-1:0] tot_cnt;

    // Divider: quotient registers start as the dividend and are shifted out
    // MSB first into the remainder while quotient bits shift in at the LSB.
    logic [SUM_WIDTH-1:0] quo_x, quo_y, rem_x, rem_y, divisor;
    logic [SUM_WIDTH-1:0] rsh_x, rsh_y;
    logic [IW-1:0]        iter;

    assign qual    = enable & pix_valid & pix_active;
    assign tot_x   = sum_x + (qual ? SUM_WIDTH'(x_pos) : '0);
    assign tot_y   = sum_y + (qual ? SUM_WIDTH'(y_pos) : '0);
    assign tot_cnt = (qual && (count != '1)) ? count + 1'b1 : count;

    assign rsh_x = {rem_x[SUM_WIDTH-2:0], quo_x[SUM_WIDTH-1]};
    assign rsh_y = {rem_y[SUM_WIDTH-2:0], quo_y[SUM_WIDTH-1]};

    // Accumulators run independently of the FSM; frame_end always restarts
    // them, so a frame arriving while busy is simply dropped.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
        end else if (frame_end) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
        end else begin
            sum_x <= tot_x;
            sum_y <= tot_y;
            count <= tot_cnt;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_ACCUM;
            quo_x     <= '0;
            quo_y     <= '0;
            rem_x     <= '0;
            rem_y     <= '0;
            divisor   <= '0;
            iter      <= '0;
            x_obj     <= '0;
            y_obj     <= '0;
            obj_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done    <= 1'b0;
            overrun <= 1'b0;
            case (state)
                ST_ACCUM: begin
                    if (frame_end) begin
                        if (tot_cnt < CNT_WIDTH'(MIN_PIXELS)) begin
                            // Too few pixels: report invalid, keep old position.
                            obj_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            quo_x   <= tot_x;
                            quo_y   <= tot_y;
                            rem_x   <= '0;
                            rem_y   <= '0;
                            divisor <= SUM_WIDTH'(tot_cnt);
                            iter    <= IW'(SUM_WIDTH);
                            busy    <= 1'b1;
                            state   <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    if (frame_end) overrun <= 1'b1;
                    if (iter == '0) begin
                        state <= ST_PUBLISH;
                    end else begin
                        iter <= iter - 1'b1;
                        if (rsh_x >= divisor) begin
                            rem_x <= rsh_x - divisor;
                            quo_x <= {quo_x[SUM_WIDTH-2:0], 1'b1};
                        end else begin
                            rem_x <= rsh_x;
                            quo_x <= {quo_x[SUM_WIDTH-2:0], 1'b0};
                        end
                        if (rsh_y >= divisor) begin
                            rem_y <= rsh_y - divisor;
                            quo_y <= {quo_y[SUM_WIDTH-2:0], 1'b1};
                        end else begin
                            rem_y <= rsh_y;
                            quo_y <= {quo_y[SUM_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                ST_PUBLISH: begin
                    if (frame_end) overrun <= 1'b1;
                    // A mean coordinate always fits DISP_WIDTH; truncation is exact.
                    x_obj     <= quo_x[DISP_WIDTH-1:0];
                    y_obj     <= quo_y[DISP_WIDTH-1:0];
                    obj_valid <= 1'b1;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_ACCUM;
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_object_centroid.sv
// Directed bench for object_centroid: hand-computed centroids, short frames,
// frame_end pixel inclusion, overrun, enable gating and reset during division.
module tb_object_centroid;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_active = 1'b0;
    logic [10:0] x_pos = '0;
    logic [10:0] y_pos = '0;
    logic        frame_end = 1'b0;
    logic [10:0] x_obj, y_obj;
    logic        obj_valid, done, busy, overrun;

    int n_cmp = 0;
    int n_err = 0;

    object_centroid dut (
        .clk(clk), .aresetn(aresetn), .enable(enable),
        .pix_valid(pix_valid), .pix_active(pix_active),
        .x_pos(x_pos), .y_pos(y_pos), .frame_end(frame_end),
        .x_obj(x_obj), .y_obj(y_obj), .obj_valid(obj_valid),
        .done(done), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic pix(input int x, input int y);
        pix_valid = 1'b1; pix_active = 1'b1;
        x_pos = 11'(x); y_pos = 11'(y);
        @(posedge clk); #1;
        pix_valid = 1'b0; pix_active = 1'b0;
    endtask

    task automatic fend(input logic with_pix, input int x, input int y);
        frame_end = 1'b1;
        pix_valid = with_pix; pix_active = with_pix;
        x_pos = 11'(x); y_pos = 11'(y);
        @(posedge clk); #1;
        frame_end = 1'b0; pix_valid = 1'b0; pix_active = 1'b0;
    endtask

    // Sample now (index 0 = just after the frame_end edge) and after n more edges.
    task automatic observe(input int n, output int d_cnt, output int d_at,
                           output int b_seen, output int o_cnt);
        d_cnt = 0; d_at = -1; b_seen = 0; o_cnt = 0;
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (done) begin d_cnt++; if (d_at < 0) d_at = i; end
            if (busy) b_seen = 1;
            if (overrun) o_cnt++;
        end
    endtask

    int dc, da, bs, oc;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_x", x_obj, 0);
        chk("rst_valid", obj_valid, 0);
        chk("rst_busy_done", {busy, done, overrun}, 0);
        aresetn = 1'b1;
        @(posedge clk); #1;

        // 4x4 block: mean (101.5, 51.5) truncates to (101, 51)
        for (int y = 50; y < 54; y++)
            for (int x = 100; x < 104; x++) pix(x, y);
        fend(1'b0, 0, 0);
        chk("t1_busy0", busy, 1);
        observe(40, dc, da, bs, oc);
        chk("t1_done_at", da, 32);
        chk("t1_done_cnt", dc, 1);
        chk("t1_x", x_obj, 101);
        chk("t1_y", y_obj, 51);
        chk("t1_valid", obj_valid, 1);
        chk("t1_busy_end", busy, 0);

        // 15 pixels: too few, old position held
        for (int i = 0; i < 15; i++) pix(300 + i, 20);
        fend(1'b0, 0, 0);
        observe(40, dc, da, bs, oc);
        chk("t2_done_at", da, 0);
        chk("t2_done_cnt", dc, 1);
        chk("t2_valid", obj_valid, 0);
        chk("t2_x", x_obj, 101);
        chk("t2_y", y_obj, 51);
        chk("t2_busy", bs, 0);

        // 16th pixel arrives in the frame_end cycle
        for (int i = 0; i < 15; i++) pix(200, 10);
        fend(1'b1, 200, 10);
        observe(40, dc, da, bs, oc);
        chk("t3_done_at", da, 32);
        chk("t3_x", x_obj, 200);
        chk("t3_y", y_obj, 10);
        chk("t3_valid", obj_valid, 1);
        // next frame must start from count 0: 15 pixels is short
        for (int i = 0; i < 15; i++) pix(5, 5);
        fend(1'b0, 0, 0);
        observe(40, dc, da, bs, oc);
        chk("t3_restart_valid", obj_valid, 0);
        chk("t3_restart_x", x_obj, 200);

        // Overrun: second frame_end 5 cycles into the division
        for (int i = 0; i < 16; i++) pix(40, 60);
        fend(1'b0, 0, 0);
        for (int i = 0; i < 4; i++) pix(300, 300);
        fend(1'b0, 0, 0);
        chk("t4_overrun", overrun, 1);
        observe(40, dc, da, bs, oc);
        chk("t4_ovr_cnt", oc, 1);
        chk("t4_done_at", da, 27);
        chk("t4_done_cnt", dc, 1);
        chk("t4_x", x_obj, 40);
        chk("t4_y", y_obj, 60);
        for (int i = 0; i < 15; i++) pix(1, 1);
        fend(1'b0, 0, 0);
        observe(40, dc, da, bs, oc);
        chk("t4_empty_valid", obj_valid, 0);
        chk("t4_empty_busy", bs, 0);

        // enable low for a whole frame
        enable = 1'b0;
        for (int i = 0; i < 20; i++) pix(7, 9);
        fend(1'b1, 7, 9);
        observe(40, dc, da, bs, oc);
        chk("t5_done_at", da, 0);
        chk("t5_valid", obj_valid, 0);
        chk("t5_busy", bs, 0);
        enable = 1'b1;
        for (int i = 0; i < 16; i++) pix(7, 9);
        fend(1'b0, 0, 0);
        observe(40, dc, da, bs, oc);
        chk("t5_x", x_obj, 7);
        chk("t5_y", y_obj, 9);
        chk("t5_valid_on", obj_valid, 1);

        // Reset at cycle 10 of the division
        for (int i = 0; i < 16; i++) pix(500, 400);
        fend(1'b0, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        aresetn = 1'b0;
        #1;
        chk("t6_x", x_obj, 0);
        chk("t6_y", y_obj, 0);
        chk("t6_flags", {obj_valid, busy, done}, 0);
        @(posedge clk); @(posedge clk); #1;
        aresetn = 1'b1;
        observe(40, dc, da, bs, oc);
        chk("t6_no_done", dc, 0);
        chk("t6_no_busy", bs, 0);
        // x = 0..15 -> mean 7.5 -> 7, y = 5
        for (int i = 0; i < 16; i++) pix(i, 5);
        fend(1'b0, 0, 0);
        observe(40, dc, da, bs, oc);
        chk("t6_done_at", da, 32);
        chk("t6_x_after", x_obj, 7);
        chk("t6_y_after", y_obj, 5);
        chk("t6_valid_after", obj_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/object_centroid.md
Name: object_centroid

Overview:
Computes the object's centre for each video frame. It accumulates the coordinates of every pixel flagged as "object" during the frame. At end of frame, an iterative divider turns the sums into a mean x/y position. Sits directly upstream of the overlay colouring stage and drives its x_obj/y_obj inputs; the result is held stable for the whole of the following frame.

Parameters:
DISP_WIDTH, 11, width of coordinate inputs and centroid outputs
CNT_WIDTH, 19, width of the object-pixel counter (>= log2 of pixels per frame)
SUM_WIDTH, 30, width of the coordinate accumulators and divider (>= CNT_WIDTH + DISP_WIDTH)
MIN_PIXELS, 16, minimum object-pixel count for a frame's centroid to be published

Ports:
clk  in  1  system clock
aresetn  in  1  asynchronous active-low reset
enable  in  1  accumulation enable; when low, pixels are ignored
pix_valid  in  1  x_pos/y_pos/pix_active valid this cycle
pix_active  in  1  pixel belongs to the object (thresholded mask)
x_pos  in  DISP_WIDTH  current pixel column
y_pos  in  DISP_WIDTH  current pixel row
frame_end  in  1  one-cycle pulse after the last pixel of a frame
x_obj  out  DISP_WIDTH  centroid column, registered
y_obj  out  DISP_WIDTH  centroid row, registered
obj_valid  out  1  last processed frame produced a valid centroid
done  out  1  one-cycle pulse when x_obj/y_obj/obj_valid update
busy  out  1  divider active
overrun  out  1  one-cycle pulse: frame_end arrived while busy

Behaviour:
- Reset (aresetn low, async): sum_x, sum_y, count, x_obj, y_obj = 0; obj_valid, done, busy, overrun = 0; FSM = ACCUM; divider registers cleared.
- Accumulators run independently of the FSM. Each cycle with enable & pix_valid & pix_active & ~frame_end-clear: sum_x += x_pos, sum_y += y_pos, count += 1.
- count saturates at all-ones. Sums are sized by parameter so they never wrap; overflow behaviour is undefined outside legal parameter sets.
- frame_end cycle with a qualifying pixel: that pixel is included in the closing frame's totals, i.e. the latched value = sum + pixel. Accumulators then restart at 0 on the next edge.
- frame_end always clears the accumulators, regardless of enable or FSM state.
- FSM states:
  - ACCUM: on frame_end:
    - If count_total < MIN_PIXELS: obj_valid <= 0, done pulse next cycle, x_obj/y_obj hold previous values, stay in ACCUM.
    - Else: latch dividends (sum_x, sum_y) and divisor (count) into the divider, busy <= 1, go to DIV.
  - DIV: restoring division of x and y in parallel, one quotient bit per cycle, MSB first. Runs exactly SUM_WIDTH cycles, then goes to PUBLISH.
  - PUBLISH: x_obj <= quot_x[DISP_WIDTH-1:0], y_obj <= quot_y[DISP_WIDTH-1:0] (quotients are truncated, not rounded; a mean coordinate always fits). Also obj_valid <= 1, done <= 1 for one cycle, busy <= 0, return to ACCUM.
- Latency: new x_obj/y_obj/obj_valid/done are visible exactly SUM_WIDTH+2 cycles after the edge that samples frame_end.
- frame_end while busy (DIV or PUBLISH):
  - Accumulators are cleared and that frame is discarded.
  - overrun pulses one cycle.
  - The in-flight division completes normally.
- x_obj/y_obj never change except in PUBLISH or at reset. There are no glitches during DIV.
- Reset mid-DIV aborts the division: outputs return to reset values and no done pulse is issued.
- Divisor is never 0 in DIV (MIN_PIXELS >= 1 is required).

Test Plan:
- 4x4 object block x=100..103, y=50..53, frame_end -> after 32 cycles (defaults) x_obj=101, y_obj=51, obj_valid=1, done pulses exactly once.
- Only 15 active pixels, previous result (101,51) -> done pulses, obj_valid=0, x_obj/y_obj remain 101/51, busy never asserts.
- Active pixel (x=200, y=10) asserted in the same cycle as frame_end, with 15 earlier pixels at (200,10) -> count=16, x_obj=200, y_obj=10; next frame starts from count 0.
- Second frame_end 5 cycles after the first -> overrun pulses once, first frame's result published unchanged, second frame dropped, accumulators empty.
- enable=0 for whole frame with active pixels -> count 0 at frame_end, obj_valid=0; re-enable -> normal results resume.
- aresetn low at cycle 10 of DIV -> all outputs 0 immediately, no done; a subsequent valid frame produces the correct centroid.
